branch_predictor: RTL and testbench
===================================

# branch_predictor

Fetch-stage direction predictor and redirect unit for the RV32I pipeline. Each cycle it combines the BTB target read for the current fetch PC with a gshare pattern history table (PHT) of 2-bit saturating counters, and produces the predicted next PC. At EX it resolves branches, trains the PHT, repairs the speculative global history, raises the misprediction redirect and drives the BTB write-enable. It sits directly downstream of the BTB read port and upstream of its write port.

## Interface
- HIST_BITS, 8: global history length; PHT has 2^HIST_BITS entries.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- fetch_pc  in  32  PC presented to the BTB this cycle.
- fetch_stall  in  1  fetch held this cycle; speculative history is frozen.
- btb_target  in  32  BTB read data for fetch_pc, valid in the same cycle.
- pred_taken  out  1  fetch predicts taken.
- pred_pc  out  32  next fetch PC.
- pred_index  out  HIST_BITS  PHT index used, carried down the pipeline.
- pred_ghr  out  HIST_BITS  GHR value before this prediction, carried down the pipeline.
- ex_valid, ex_is_branch, ex_taken, ex_pred_taken  in  1 each  EX-stage instruction flags.
- ex_pc, ex_target, ex_pred_pc  in  32 each  EX-stage PC, resolved target, and PC predicted at fetch.
- ex_index, ex_ghr  in  HIST_BITS each  values carried from pred_index/pred_ghr.
- mispredict  out  1  flush and redirect fetch.
- redirect_pc  out  32  correct next PC.
- btb_load  out  1  write-enable to the BTB (index ex_pc[11:2], data ex_target).
- branch_count, mispredict_count  out  32 each  performance counters.

## Operation
- State: PHT (2^HIST_BITS × 2 bits), valid vector (1024 bits, indexed by PC[11:2]), GHR (HIST_BITS), two 32-bit counters.
- Index: pred_index = fetch_pc[HIST_BITS+1:2] XOR GHR.
- Prediction: pred_taken = valid[fetch_pc[11:2]] AND PHT[pred_index][1]. pred_pc = btb_target when pred_taken, else fetch_pc+4 (mod 2^32).
- GHR speculative update: at the clock edge, when !fetch_stall and valid[fetch_pc[11:2]], GHR <= {GHR[HIST_BITS-2:0], pred_taken}.
- Resolution, when ex_valid:
  - branch: mispredict = (ex_taken != ex_pred_taken) OR (ex_taken AND ex_target != ex_pred_pc).
  - non-branch: mispredict = ex_pred_taken.
- redirect_pc = ex_target if ex_is_branch AND ex_taken, else ex_pc+4.
- Training on ex_valid AND ex_is_branch:
  - taken: PHT[ex_index] increments, saturating at 3.
  - not taken: PHT[ex_index] decrements, saturating at 0.
  - taken: btb_load = 1 and valid[ex_pc[11:2]] <= 1.
- GHR repair: on mispredict, GHR <= {ex_ghr[HIST_BITS-2:0], ex_taken} for a branch, or GHR <= ex_ghr for a non-branch. Repair overrides the speculative shift in the same cycle, including when fetch_stall is low.
- Counters:
  - branch_count increments on each resolved branch.
  - mispredict_count increments on each mispredict.
  - Both saturate at 0xFFFFFFFF.
- Valid bits are never cleared except by reset.

## Timing
- Prediction is combinational: fetch_pc/btb_target to pred_* in the same cycle. mispredict, redirect_pc and btb_load are combinational from ex_* inputs.
- Same-cycle PHT write and fetch read of one index: fetch sees the pre-write value, with no bypass. The same rule applies to the valid vector.
- State updates take effect at the next rising edge.
- Reset, asynchronous, takes effect immediately, including mid-operation:
  - PHT all 2'b01 (weakly not-taken).
  - valid all 0, GHR 0, counters 0.
  - Result: pred_taken 0 and pred_pc = fetch_pc+4.
  - While rst is high, mispredict and btb_load are forced to 0 and redirect_pc is don't-care.
- A stalled fetch still allows EX training and repair.

## Test plan
- Reset, then fetch_pc=0x0000_0040 with btb_target=0x0000_0100: pred_taken=0, pred_pc=0x0000_0044, all counters 0.
- Resolve a taken branch twice at ex_pc=0x40 (ex_index=0x10, ex_target=0x100, ex_pred_taken=0):
  - First resolution: mispredict=1, redirect_pc=0x100, btb_load=1.
  - After both resolutions: PHT[0x10]=3.
  - Fetch of 0x40 with GHR=0 then gives pred_taken=1, pred_pc=0x100.
- Saturation: 5 not-taken resolutions on one index leave the counter at 0 (redirect_pc=ex_pc+4); 5 taken resolutions leave it at 3.
- GHR: three predicted-taken fetches with stall low give GHR=0x07. A mispredict with ex_ghr=0x05 and ex_taken=0 in the same cycle as a fetch shift gives GHR=0x0A.
- Non-branch with ex_pred_taken=1, ex_pc=0x200: mispredict=1, redirect_pc=0x204, no PHT change, btb_load=0.
- Assert rst mid-run with counters nonzero: all state returns to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/branch_predictor.sv
// Fetch-stage gshare direction predictor with EX-stage resolution, PHT training,
// speculative global-history repair, BTB write-enable and performance counters.
module branch_predictor #(
  parameter int HIST_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          fetch_pc,
  input  logic                 fetch_stall,
  input  logic [31:0]          btb_target,
  output logic                 pred_taken,
  output logic [31:0]          pred_pc,
  output logic [HIST_BITS-1:0] pred_index,
  output logic [HIST_BITS-1:0] pred_ghr,
  input  logic                 ex_valid,
  input  logic                 ex_is_branch,
  input  logic                 ex_taken,
  input  logic                 ex_pred_taken,
  input  logic [31:0]          ex_pc,
  input  logic [31:0]          ex_target,
  input  logic [31:0]          ex_pred_pc,
  input  logic [HIST_BITS-1:0] ex_index,
  input  logic [HIST_BITS-1:0] ex_ghr,
  output logic                 mispredict,
  output logic [31:0]          redirect_pc,
  output logic                 btb_load,
  output logic [31:0]          branch_count,
  output logic [31:0]          mispredict_count
);

  localparam int PHT_N = 1 << HIST_BITS;

  // PHT is kept in flops: it needs an asynchronous reset to weakly-not-taken.
  logic [1:0]           pht_q [PHT_N];
  logic [1023:0]        valid_q;
  logic [HIST_BITS-1:0] ghr_q, ghr_d;
  logic [31:0]          branch_count_q, mispredict_count_q;

  logic                 fetch_valid;
  logic                 ex_branch;
  logic                 mispredict_raw;
  logic [1:0]           pht_cur;
  logic [1:0]           pht_new;

  // Fetch-side prediction: purely combinational from fetch_pc, btb_target and state.
  always_comb begin
    pred_index  = fetch_pc[HIST_BITS+1:2] ^ ghr_q;
    pred_ghr    = ghr_q;
    fetch_valid = valid_q[fetch_pc[11:2]];
    pred_taken  = fetch_valid & pht_q[pred_index][1];
    pred_pc     = pred_taken ? btb_target : (fetch_pc + 32'd4);
  end

  // EX-side resolution; visible outputs are held quiet while reset is asserted.
  always_comb begin
    ex_branch = ex_valid & ex_is_branch;
    if (ex_is_branch) begin
      mispredict_raw = ex_valid & ((ex_taken != ex_pred_taken) |
                                   (ex_taken & (ex_target != ex_pred_pc)));
    end else begin
      mispredict_raw = ex_valid & ex_pred_taken;
    end
    mispredict  = mispredict_raw & ~rst;
    btb_load    = ex_branch & ex_taken & ~rst;
    redirect_pc = (ex_is_branch & ex_taken) ? ex_target : (ex_pc + 32'd4);
  end

  // Saturating counter step for the PHT entry being trained.
  always_comb begin
    pht_cur = pht_q[ex_index];
    pht_new = pht_cur;
    if (ex_taken) begin
      if (pht_cur != 2'b11) pht_new = pht_cur + 2'b01;
    end else begin
      if (pht_cur != 2'b00) pht_new = pht_cur - 2'b01;
    end
  end

  // Next global history: repair from EX wins over the speculative fetch shift.
  always_comb begin
    ghr_d = ghr_q;
    if (mispredict_raw) begin
      ghr_d = ex_is_branch ? {ex_ghr[HIST_BITS-2:0], ex_taken} : ex_ghr;
    end else if (!fetch_stall && fetch_valid) begin
      ghr_d = {ghr_q[HIST_BITS-2:0], pred_taken};
    end
  end

  // PHT training on every resolved branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PHT_N; i++) pht_q[i] <= 2'b01;
    end else if (ex_branch) begin
      pht_q[ex_index] <= pht_new;
    end
  end

  // Valid bits mark PCs that have a taken-branch target in the BTB; set only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (ex_branch && ex_taken) begin
      valid_q[ex_pc[11:2]] <= 1'b1;
    end
  end

  // Global history register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ghr_q <= '0;
    else     ghr_q <= ghr_d;
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      if (ex_branch && !(&branch_count_q))
        branch_count_q <= branch_count_q + 32'd1;
      if (mispredict_raw && !(&mispredict_count_q))
        mispredict_count_q <= mispredict_count_q + 32'd1;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor with hand-computed expectations.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        fetch_stall;
  logic [31:0] btb_target;
  logic        pred_taken;
  logic [31:0] pred_pc;
  logic [7:0]  pred_index;
  logic [7:0]  pred_ghr;
  logic        ex_valid, ex_is_branch, ex_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_pc;
  logic [7:0]  ex_index, ex_ghr;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        btb_load;
  logic [31:0] branch_count, mispredict_count;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  branch_predictor #(.HIST_BITS(8)) dut (
    .clk(clk), .rst(rst),
    .fetch_pc(fetch_pc), .fetch_stall(fetch_stall), .btb_target(btb_target),
    .pred_taken(pred_taken), .pred_pc(pred_pc),
    .pred_index(pred_index), .pred_ghr(pred_ghr),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_taken(ex_taken),
    .ex_pred_taken(ex_pred_taken), .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_pred_pc(ex_pred_pc), .ex_index(ex_index), .ex_ghr(ex_ghr),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .btb_load(btb_load),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_set(input logic v, input logic br, input logic tk, input logic ptk,
                        input logic [31:0] pc, input logic [31:0] tgt, input logic [31:0] ppc,
                        input logic [7:0] idx, input logic [7:0] gh);
    ex_valid = v; ex_is_branch = br; ex_taken = tk; ex_pred_taken = ptk;
    ex_pc = pc; ex_target = tgt; ex_pred_pc = ppc; ex_index = idx; ex_ghr = gh;
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] tgt, input logic stall);
    fetch_pc = pc; btb_target = tgt; fetch_stall = stall;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    fetch_pc = 32'h40; btb_target = 32'h100; fetch_stall = 1'b1;
    // Non-branch mispredict condition during reset must be suppressed.
    ex_set(1, 0, 0, 1, 32'h200, 32'h0, 32'h0, 8'h00, 8'h00);
    check("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    check("rst_pred_pc", pred_pc, 32'h44);
    check("rst_mispredict", {31'd0, mispredict}, 32'd0);
    check("rst_btb_load", {31'd0, btb_load}, 32'd0);
    check("rst_branch_cnt", branch_count, 32'd0);
    check("rst_mispr_cnt", mispredict_count, 32'd0);
    check("rst_ghr", {24'd0, pred_ghr}, 32'd0);
    ex_set(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 8'h00, 8'h00);
    tick();
    rst = 1'b0;
    tick();

    // First taken resolution at 0x40, predicted not taken: mispredict.
    ex_set(1, 1, 1, 0, 32'h40, 32'h100, 32'h44, 8'h10, 8'h00);
    check("br1_mispredict", {31'd0, mispredict}, 32'd1);
    check("br1_redirect", redirect_pc, 32'h100);
    check("br1_btb_load", {31'd0, btb_load}, 32'd1);
    tick();
    // Second taken resolution, correctly predicted.
    ex_set(1, 1, 1, 1, 32'h40, 32'h100, 32'h100, 8'h10, 8'h01);
    check("br2_mispredict", {31'd0, mispredict}, 32'd0);
    tick();
    check("ghr_after_br_repair", {24'd0, pred_ghr}, 32'h01);
    // Non-branch predicted taken: mispredict, repairs GHR to ex_ghr=0.
    ex_set(1, 0, 0, 1, 32'h200, 32'h900, 32'h900, 8'h10, 8'h00);
    check("nb_mispredict", {31'd0, mispredict}, 32'd1);
    check("nb_redirect", redirect_pc, 32'h204);
    check("nb_btb_load", {31'd0, btb_load}, 32'd0);
    tick();
    ex_set(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 8'h00, 8'h00);
    check("cnt_branch_a", branch_count, 32'd2);
    check("cnt_mispr_a", mispredict_count, 32'd2);
    fetch(32'h40, 32'h100, 1'b1);
    check("fetch40_taken", {31'd0, pred_taken}, 32'd1);
    check("fetch40_pc", pred_pc, 32'h100);
    check("fetch40_index", {24'd0, pred_index}, 32'h10);
    check("fetch40_ghr", {24'd0, pred_ghr}, 32'h00);

    // Saturation at 0: five not-taken resolutions on index 0x20.
    for (int i = 0; i < 5; i++) begin
      ex_set(1, 1, 0, 0, 32'h80, 32'h300, 32'h84, 8'h20, 8'h00);
      check($sformatf("nt%0d_redirect", i), redirect_pc, 32'h84);
      tick();
    end
    // One taken: counter 0 -> 1, and valid for PC 0x80 is set.
    ex_set(1, 1, 1, 1, 32'h80, 32'h300, 32'h300, 8'h20, 8'h00);
    check("t_mispredict", {31'd0, mispredict}, 32'd0);
    tick();
    ex_set(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 8'h00, 8'h00);
    fetch(32'h80, 32'h300, 1'b1);
    check("sat0_pred_taken", {31'd0, pred_taken}, 32'd0);
    check("sat0_pred_pc", pred_pc, 32'h84);
    // Saturation at 3: five taken (1 -> 3), then one not-taken leaves 2.
    for (int i = 0; i < 5; i++) begin
      ex_set(1, 1, 1, 1, 32'h80, 32'h300, 32'h300, 8'h20, 8'h00);
      tick();
    end
    ex_set(1, 1, 0, 0, 32'h80, 32'h300, 32'h84, 8'h20, 8'h00);
    tick();
    ex_set(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 8'h00, 8'h00);
    check("sat3_pred_taken", {31'd0, pred_taken}, 32'd1);
    check("sat3_pred_pc", pred_pc, 32'h300);
    check("cnt_branch_b", branch_count, 32'd14);
    check("cnt_mispr_b", mispredict_count, 32'd2);

    // Make PCs 0x44 and 0x4C valid; their PHT training targets saturated index 0x10.
    ex_set(1, 1, 1, 1, 32'h44, 32'h500, 32'h500, 8'h10, 8'h00);
    tick();
    ex_set(1, 1, 1, 1, 32'h4C, 32'h500, 32'h500, 8'h10, 8'h00);
    tick();
    ex_set(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 8'h00, 8'h00);

    // Three predicted-taken fetches, stall low: GHR 0 -> 1 -> 3 -> 7.
    fetch(32'h40, 32'h100, 1'b0);
    check("g0_taken", {31'd0, pred_taken}, 32'd1);
    check("g0_ghr", {24'd0, pred_ghr}, 32'h00);
    tick();
    fetch(32'h44, 32'h500, 1'b0);
    check("g1_taken", {31'd0, pred_taken}, 32'd1);
    check("g1_ghr", {24'd0, pred_ghr}, 32'h01);
    tick();
    fetch(32'h4C, 32'h500, 1'b0);
    check("g2_taken", {31'd0, pred_taken}, 32'd1);
    check("g2_ghr", {24'd0, pred_ghr}, 32'h03);
    tick();
    fetch(32'h40, 32'h100, 1'b0);
    check("g3_ghr", {24'd0, pred_ghr}, 32'h07);
    // Repair overrides a same-cycle speculative shift: {0x05[6:0],0} = 0x0A.
    ex_set(1, 1, 0, 1, 32'h600, 32'h700, 32'h700, 8'h30, 8'h05);
    check("rep_mispredict", {31'd0, mispredict}, 32'd1);
    check("rep_redirect", redirect_pc, 32'h604);
    tick();
    ex_set(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 8'h00, 8'h00);
    fetch(32'h40, 32'h100, 1'b1);
    check("rep_ghr", {24'd0, pred_ghr}, 32'h0A);
    check("cnt_branch_c", branch_count, 32'd17);
    check("cnt_mispr_c", mispredict_count, 32'd3);

    // Asynchronous reset mid-cycle, away from any clock edge.
    @(posedge clk);
    #2;
    ex_set(1, 1, 1, 0, 32'h40, 32'h100, 32'h44, 8'h10, 8'h00);
    rst = 1'b1;
    #1;
    check("arst_branch_cnt", branch_count, 32'd0);
    check("arst_mispr_cnt", mispredict_count, 32'd0);
    check("arst_ghr", {24'd0, pred_ghr}, 32'd0);
    check("arst_pred_taken", {31'd0, pred_taken}, 32'd0);
    check("arst_pred_pc", pred_pc, 32'h44);
    check("arst_mispredict", {31'd0, mispredict}, 32'd0);
    check("arst_btb_load", {31'd0, btb_load}, 32'd0);
    ex_set(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 8'h00, 8'h00);
    tick();
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
